mem_copy_engine: RTL

- Bus initiator for the single-port synchronous data SRAM (registered read data, 1-cycle read latency, read/write/address/data_in/data_out interface).
- Copies a block of LENGTH words from a source address to a destination address in the same memory.
- Alternates a read cycle and a write cycle per word.
- Sits beside the pipeline's memory stage; its memory-side outputs are muxed onto the SRAM port while busy is high.

---
 rtl/mem_copy_engine.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// Block copy engine for the single-port data SRAM: alternates read and write cycles per word.
// Optional running checksum of copied words enabled by MEMCPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int unsigned D_SIZE = 32,
    parameter int unsigned A_SIZE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [A_SIZE-1:0] src_addr,
    input  logic [A_SIZE-1:0] dst_addr,
    input  logic [A_SIZE:0]   length,
    output logic              busy,
    output logic              done,
    output logic [A_SIZE:0]   words_done,
`ifdef MEMCPY_CHECKSUM_EN
    output logic [D_SIZE-1:0] checksum,
`endif
    output logic              mem_read,
    output logic              mem_write,
    output logic [A_SIZE-1:0] mem_address,
    output logic [D_SIZE-1:0] mem_wdata,
    input  logic [D_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e            state_q;
    logic [A_SIZE-1:0] src_q;
    logic [A_SIZE-1:0] dst_q;
    logic [A_SIZE:0]   rem_q;
    logic [A_SIZE:0]   words_q;

    logic [A_SIZE-1:0] src_d;
    logic [A_SIZE-1:0] dst_d;
    logic [A_SIZE:0]   rem_d;
    logic [A_SIZE:0]   words_d;

    // Pointers wrap silently at the top of memory.
    assign src_d   = src_q + A_SIZE'(1);
    assign dst_d   = dst_q + A_SIZE'(1);
    assign rem_d   = rem_q - (A_SIZE + 1)'(1);
    assign words_d = words_q + (A_SIZE + 1)'(1);

`ifdef MEMCPY_CHECKSUM_EN
    logic [D_SIZE-1:0] cks_q;
    assign checksum = cks_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
`ifdef MEMCPY_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // start wins over a simultaneous abort; abort alone is ignored here
                    if (start) begin
                        words_q <= '0;
`ifdef MEMCPY_CHECKSUM_EN
                        cks_q   <= '0;
`endif
                        if (length != '0) begin
                            src_q   <= src_addr;
                            dst_q   <= dst_addr;
                            rem_q   <= length;
                            state_q <= S_RD;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    state_q <= abort ? S_IDLE : S_WR;
                end
                S_WR: begin
                    // The write issued this cycle always completes, even under abort.
                    src_q   <= src_d;
                    dst_q   <= dst_d;
                    rem_q   <= rem_d;
                    words_q <= words_d;
`ifdef MEMCPY_CHECKSUM_EN
                    cks_q   <= cks_q + mem_rdata;
`endif
                    if (abort)
                        state_q <= S_IDLE;
                    else if (rem_q == (A_SIZE + 1)'(1))
                        state_q <= S_FIN;
                    else
                        state_q <= S_RD;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus and status outputs decode the state register only.
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign words_done  = words_q;
    assign mem_read    = (state_q == S_RD);
    assign mem_write   = (state_q == S_WR);
    assign mem_address = (state_q == S_RD) ? src_q :
                         (state_q == S_WR) ? dst_q : '0;
    assign mem_wdata   = (state_q == S_WR) ? mem_rdata : '0;

endmodule
